// File: rtl/gps_corr_pkg.sv
// Shared definitions for the correlator bank: dump-mode constants, output FSM states
// and the accumulator width rule used by the elaboration check.
package gps_corr_pkg;

    localparam int DUMP_COUNT = 0;
    localparam int DUMP_EPOCH = 1;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // Smallest signed width that holds +/-int_len without wrapping.
    function automatic int acc_width(input int int_len);
        return $clog2(int_len + 1) + 1;
    endfunction

endpackage

// File: rtl/correlator_channel.sv
// One I/Q integrate-and-dump pair: maps each mixed bit to +1/-1 and exposes the running
// sum including the current sample so the top can capture it on the dump edge.
module correlator_channel #(
    parameter int ACC_W = 16
) (
    input  logic                    clk,
    input  logic                    sync_i,
    input  logic                    sample_en_i,
    input  logic                    sample_i,
    input  logic                    code_i,
    input  logic                    sin_i,
    input  logic                    cos_i,
    input  logic                    dump_i,
    output logic signed [ACC_W-1:0] sum_i_o,
    output logic signed [ACC_W-1:0] sum_q_o
);

    localparam logic signed [ACC_W-1:0] PLUS_ONE  = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] MINUS_ONE = '1;

    logic signed [ACC_W-1:0] acc_i_q, acc_i_d;
    logic signed [ACC_W-1:0] acc_q_q, acc_q_d;
    logic                    mix_i, mix_q;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        mix_i   = sample_i ^ code_i ^ cos_i;
        mix_q   = sample_i ^ code_i ^ sin_i;
        sum_i_o = acc_i_q;
        sum_q_o = acc_q_q;
        if (sample_en_i) begin
            sum_i_o = acc_i_q + (mix_i ? MINUS_ONE : PLUS_ONE);
            sum_q_o = acc_q_q + (mix_q ? MINUS_ONE : PLUS_ONE);
        end
        // A dump hands the sum to the output registers and starts the next block empty.
        acc_i_d = dump_i ? '0 : sum_i_o;
        acc_q_d = dump_i ? '0 : sum_q_o;
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so all registers sample together.
        if (sync_i) begin
            acc_i_q <= '0;
            acc_q_q <= '0;
        end else begin
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
        end
    end

endmodule

// File: rtl/correlator_bank.sv
// N_CH parallel I/Q correlators on a shared 1-bit IF stream, with a shared sample counter,
// double-buffered dump registers and a valid/ready handshake toward the tracking loop.
module correlator_bank
    import gps_corr_pkg::*;
#(
    parameter int N_CH      = 3,
    parameter int INT_LEN   = 10000,
    parameter int DUMP_MODE = DUMP_COUNT,
    parameter int ACC_W     = acc_width(INT_LEN),
    parameter int CNT_W     = $clog2(INT_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  sync,
    input  logic                  sample_en,
    input  logic                  sample,
    input  logic [N_CH-1:0]       code_tap,
    input  logic                  nco_sin,
    input  logic                  nco_cos,
    input  logic                  epoch,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [N_CH*ACC_W-1:0] out_i,
    output logic [N_CH*ACC_W-1:0] out_q,
    output logic [CNT_W-1:0]      out_count,
    output logic                  overrun
);

    if (ACC_W < acc_width(INT_LEN)) begin : g_width_check
        $error("correlator_bank: ACC_W too narrow for INT_LEN");
    end

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INT_LEN - 1);

    out_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, count_now;
    logic [N_CH*ACC_W-1:0]  sum_i, sum_q;
    logic [N_CH*ACC_W-1:0]  out_i_q, out_q_q;
    logic [CNT_W-1:0]       out_count_q;
    logic                   overrun_q;
    logic                   dump, xfer;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic signed [ACC_W-1:0] ch_sum_i, ch_sum_q;

        correlator_channel #(.ACC_W(ACC_W)) u_ch (
            .clk        (clk),
            .sync_i     (sync),
            .sample_en_i(sample_en),
            .sample_i   (sample),
            .code_i     (code_tap[k]),
            .sin_i      (nco_sin),
            .cos_i      (nco_cos),
            .dump_i     (dump),
            .sum_i_o    (ch_sum_i),
            .sum_q_o    (ch_sum_q)
        );

        assign sum_i[k*ACC_W +: ACC_W] = ch_sum_i;
        assign sum_q[k*ACC_W +: ACC_W] = ch_sum_q;
    end

    // An epoch on an empty block is ignored; the dumping sample is always included.
    always_comb begin
        count_now = cnt_q + CNT_W'(sample_en);
        dump      = (sample_en && (cnt_q == LAST_CNT)) ||
                    ((DUMP_MODE == DUMP_EPOCH) && epoch && (cnt_q != '0));
        cnt_d     = dump ? '0 : count_now;
        xfer      = out_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (sync) begin
            state_q <= OUT_EMPTY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OUT_EMPTY: if (dump)          state_d = OUT_FULL;
            OUT_FULL:  if (xfer && !dump) state_d = OUT_EMPTY;
            default:                      state_d = OUT_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q == OUT_FULL);
    end

    always_ff @(posedge clk) begin
        if (sync) begin
            out_i_q     <= '0;
            out_q_q     <= '0;
            out_count_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            if (dump) begin
                out_i_q     <= sum_i;
                out_q_q     <= sum_q;
                out_count_q <= count_now;
            end
            // Overwriting a held result the consumer has not taken is sticky until sync.
            if (dump && out_valid && !out_ready) overrun_q <= 1'b1;
        end
    end

    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign out_count = out_count_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_correlator_bank.sv
// Scoreboard bench: a counting-mode and an epoch-mode bank share one randomized stimulus
// stream; an integer reference model predicts each result and a monitor checks transfers.
module tb_correlator_bank;
    import gps_corr_pkg::*;

    localparam int N_CH    = 3;
    localparam int INT_LEN = 16;
    localparam int ACC_W   = 6;
    localparam int CNT_W   = 5;

    typedef struct {
        int cnt;
        int si [N_CH];
        int sq [N_CH];
    } res_t;

    logic                  clk = 1'b0;
    logic                  sync, sample_en, sample, nco_sin, nco_cos, epoch, out_ready;
    logic [N_CH-1:0]       code_tap;
    logic                  valid_o [2];
    logic [N_CH*ACC_W-1:0] oi [2];
    logic [N_CH*ACC_W-1:0] oq [2];
    logic [CNT_W-1:0]      ocnt [2];
    logic                  ovr [2];

    int   n_cmp = 0;
    int   n_bad = 0;

    int   m_acc_i [2][N_CH];
    int   m_acc_q [2][N_CH];
    int   m_cnt [2];
    bit   m_valid [2];
    bit   m_ovr [2];
    bit   vis_valid [2] = '{1'b0, 1'b0};
    bit   vis_ovr [2]   = '{1'b0, 1'b0};
    res_t sb0 [$];
    res_t sb1 [$];

    always #5 clk = ~clk;

    correlator_bank #(.N_CH(N_CH), .INT_LEN(INT_LEN), .DUMP_MODE(DUMP_COUNT),
                      .ACC_W(ACC_W), .CNT_W(CNT_W)) dut_cnt (
        .clk(clk), .sync(sync), .sample_en(sample_en), .sample(sample), .code_tap(code_tap),
        .nco_sin(nco_sin), .nco_cos(nco_cos), .epoch(epoch), .out_ready(out_ready),
        .out_valid(valid_o[0]), .out_i(oi[0]), .out_q(oq[0]), .out_count(ocnt[0]),
        .overrun(ovr[0])
    );

    correlator_bank #(.N_CH(N_CH), .INT_LEN(INT_LEN), .DUMP_MODE(DUMP_EPOCH),
                      .ACC_W(ACC_W), .CNT_W(CNT_W)) dut_epc (
        .clk(clk), .sync(sync), .sample_en(sample_en), .sample(sample), .code_tap(code_tap),
        .nco_sin(nco_sin), .nco_cos(nco_cos), .epoch(epoch), .out_ready(out_ready),
        .out_valid(valid_o[1]), .out_i(oi[1]), .out_q(oq[1]), .out_count(ocnt[1]),
        .overrun(ovr[1])
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dut_i(input int d, input int k);
        logic signed [ACC_W-1:0] v;
        v = oi[d][k*ACC_W +: ACC_W];
        return int'(v);
    endfunction

    function automatic int dut_q(input int d, input int k);
        logic signed [ACC_W-1:0] v;
        v = oq[d][k*ACC_W +: ACC_W];
        return int'(v);
    endfunction

    // Reference model: what the next clock edge does to bank d, in plain integer terms.
    task automatic model_step(input int d, input bit en, input bit s, input logic [N_CH-1:0] code,
                              input bit sn, input bit cs, input bit ep, input bit rdy, input bit sy);
        bit   dump_now, xfer_now;
        res_t r;
        if (sy) begin
            for (int k = 0; k < N_CH; k++) begin
                m_acc_i[d][k] = 0;
                m_acc_q[d][k] = 0;
            end
            m_cnt[d] = 0; m_valid[d] = 0; m_ovr[d] = 0;
            if (d == 0) sb0.delete(); else sb1.delete();
            return;
        end
        xfer_now = m_valid[d] && rdy;
        dump_now = (en && m_cnt[d] == INT_LEN - 1) || (d == 1 && ep && m_cnt[d] > 0);
        if (en) begin
            for (int k = 0; k < N_CH; k++) begin
                m_acc_i[d][k] += (s ^ code[k] ^ cs) ? -1 : 1;
                m_acc_q[d][k] += (s ^ code[k] ^ sn) ? -1 : 1;
            end
            m_cnt[d]++;
        end
        if (dump_now) begin
            r.cnt = m_cnt[d];
            for (int k = 0; k < N_CH; k++) begin
                r.si[k] = m_acc_i[d][k];
                r.sq[k] = m_acc_q[d][k];
                m_acc_i[d][k] = 0;
                m_acc_q[d][k] = 0;
            end
            m_cnt[d] = 0;
            if (m_valid[d] && !rdy) begin
                m_ovr[d] = 1;
                if (d == 0) void'(sb0.pop_back()); else void'(sb1.pop_back());
            end
            if (d == 0) sb0.push_back(r); else sb1.push_back(r);
            m_valid[d] = 1;
        end else if (xfer_now) begin
            m_valid[d] = 0;
        end
    endtask

    task automatic drive(input bit en, input bit s, input logic [N_CH-1:0] code, input bit sn,
                         input bit cs, input bit ep, input bit rdy, input bit sy);
        @(posedge clk);
        #1;
        sample_en = en; sample = s; code_tap = code; nco_sin = sn; nco_cos = cs;
        epoch = ep; out_ready = rdy; sync = sy;
        model_step(0, en, s, code, sn, cs, ep, rdy, sy);
        model_step(1, en, s, code, sn, cs, ep, rdy, sy);
    endtask

    task automatic idle(input bit rdy);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    task automatic block(input int n, input bit s, input logic [N_CH-1:0] code, input bit sn,
                         input bit cs, input bit rdy);
        for (int j = 0; j < n; j++) drive(1'b1, s, code, sn, cs, 1'b0, rdy, 1'b0);
    endtask

    task automatic monitor();
        res_t r;
        int   depth;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("out_valid[%0d]", d), int'(valid_o[d]), int'(vis_valid[d]));
            check($sformatf("overrun[%0d]", d), int'(ovr[d]), int'(vis_ovr[d]));
            if (valid_o[d] === 1'b1 && out_ready === 1'b1) begin
                depth = (d == 0) ? sb0.size() : sb1.size();
                if (depth == 0) begin
                    check($sformatf("sb_underflow[%0d]", d), depth, 1);
                end else begin
                    r = (d == 0) ? sb0.pop_front() : sb1.pop_front();
                    check($sformatf("count[%0d]", d), int'(ocnt[d]), r.cnt);
                    for (int k = 0; k < N_CH; k++) begin
                        check($sformatf("sum_i[%0d][%0d]", d, k), dut_i(d, k), r.si[k]);
                        check($sformatf("sum_q[%0d][%0d]", d, k), dut_q(d, k), r.sq[k]);
                    end
                end
            end
        end
    endtask

    // The model is one edge ahead of the DUT; latch its view at each edge for the monitor.
    initial forever begin
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            vis_valid[d] = m_valid[d];
            vis_ovr[d]   = m_ovr[d];
        end
    end

    initial forever begin
        @(negedge clk);
        monitor();
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sync = 1'b1; sample_en = 1'b0; sample = 1'b0; code_tap = '0;
        nco_sin = 1'b0; nco_cos = 1'b0; epoch = 1'b0; out_ready = 1'b0;
        model_step(0, 0, 0, '0, 0, 0, 0, 0, 1);
        model_step(1, 0, 0, '0, 0, 0, 0, 0, 1);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_i[%0d]", d), int'(oi[d]), 0);
            check($sformatf("rst_q[%0d]", d), int'(oq[d]), 0);
            check($sformatf("rst_cnt[%0d]", d), int'(ocnt[d]), 0);
        end

        // All-zero inputs: every product is +1.
        block(INT_LEN, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        @(negedge clk);
        check("t1_valid", int'(valid_o[0]), 1);
        check("t1_count", int'(ocnt[0]), 16);
        check("t1_i2", dut_i(0, 2), 16);
        check("t1_q0", dut_q(0, 0), 16);
        idle(1'b1);

        // Sample=1, code 010, sin=1: ch1 flips sign relative to ch0/ch2.
        block(INT_LEN, 1'b1, 3'b010, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        @(negedge clk);
        check("t2_i0", dut_i(0, 0), -16);
        check("t2_q0", dut_q(0, 0), 16);
        check("t2_i1", dut_i(0, 1), 16);
        check("t2_q1", dut_q(0, 1), -16);
        idle(1'b1);

        // Two dumps with no consumer: second overwrites the first.
        block(INT_LEN, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        block(INT_LEN, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        @(negedge clk);
        check("t3_overrun", int'(ovr[0]), 1);
        check("t3_i0", dut_i(0, 0), -16);

        // Transfer on the exact dump edge of block 2: no overrun, valid stays high.
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        block(INT_LEN, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        block(INT_LEN - 1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        @(negedge clk);
        check("t4_valid", int'(valid_o[0]), 1);
        check("t4_overrun", int'(ovr[0]), 0);
        check("t4_q1", dut_q(0, 1), -16);
        idle(1'b1);

        // Sync mid-block discards the partial sums.
        block(7, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        @(negedge clk);
        check("t5_rst_valid", int'(valid_o[0]), 0);
        check("t5_rst_i", int'(oi[0]), 0);
        block(INT_LEN, 1'b0, 3'b101, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        @(negedge clk);
        check("t5_count", int'(ocnt[0]), 16);
        check("t5_i0", dut_i(0, 0), 16);
        check("t5_i1", dut_i(0, 1), -16);
        idle(1'b1);

        // Epoch after 5 samples dumps only the epoch-mode bank.
        block(5, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        @(negedge clk);
        check("t6_epoch_count", int'(ocnt[1]), 5);
        check("t6_epoch_i0", dut_i(1, 0), 5);
        check("t6_cnt_mode_valid", int'(valid_o[0]), 0);
        idle(1'b1);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        @(negedge clk);
        check("t6_empty_epoch", int'(valid_o[1]), 0);
        block(INT_LEN, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        @(negedge clk);
        check("t6_ceiling_count", int'(ocnt[1]), 16);
        idle(1'b1);
        idle(1'b1);

        // Randomized traffic, including back-pressure, epochs and occasional sync.
        for (int n = 0; n < 3000; n++) begin
            bit sy;
            sy = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 9) < 7, 1'($urandom()), N_CH'($urandom()), 1'($urandom()),
                  1'($urandom()), $urandom_range(0, 19) == 0, sy ? 1'b0 : 1'($urandom()), sy);
        end

        for (int n = 0; n < 4; n++) idle(1'b1);
        @(negedge clk);
        check("drain_sb0", sb0.size(), 0);
        check("drain_sb1", sb1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
